// File: rtl/hpdcache_sram_ctrl.sv
// hpdcache_sram_ctrl
//   Initiator side of a 1RW SRAM macro (cs/we/addr/wdata in, rdata one cycle after a read cs).
//   Client read/write requests use valid/ready; read data is captured into a small response
//   FIFO whose free space is reserved before a read is issued (credit scheme), so the client may
//   stall rsp_ready indefinitely without losing data.
//
//   Optional feature macro: HPDCACHE_SRAM_INIT_EN
//     defined   : after reset the whole array is zero-written, one word per cycle, before the
//                 client is admitted.
//     undefined : INIT lasts a single idle cycle.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_we, req_addr, req_wdata       request type (1 = write), word address, write data
//   rsp_valid/rsp_ready, rsp_rdata    read response handshake and data (in request order)
//   init_done                         array ready for client traffic
//   sram_cs, sram_we, sram_addr,
//   sram_wdata, sram_rdata            SRAM macro pins
module hpdcache_sram_ctrl #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned DEPTH     = 2 ** ADDR_SIZE,
    parameter int unsigned RSP_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_SIZE-1:0] rsp_rdata,
    output logic                 init_done,
    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [ADDR_SIZE-1:0] sram_addr,
    output logic [DATA_SIZE-1:0] sram_wdata,
    input  logic [DATA_SIZE-1:0] sram_rdata
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RSP_DEPTH - 1);
    localparam logic [ADDR_SIZE:0] DEPTH_EXT = (ADDR_SIZE + 1)'(DEPTH);

    typedef enum logic {StInit, StRun} state_t;

    state_t state_q;
    logic   init_done_q;

    logic                 rd_inflight_q;
    logic [CNT_W-1:0]     count_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [DATA_SIZE-1:0] mem_q [RSP_DEPTH];

    logic             run;
    logic [CNT_W:0]   credit_used;
    logic             push;
    logic             pop;

`ifdef HPDCACHE_SRAM_INIT_EN
    localparam logic [ADDR_SIZE-1:0] INIT_LAST = ADDR_SIZE'(DEPTH - 1);
    logic [ADDR_SIZE-1:0] init_addr_q;
`endif

    // Init/run sequencer; RUN is left only through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInit;
            init_done_q <= 1'b0;
`ifdef HPDCACHE_SRAM_INIT_EN
            init_addr_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StInit: begin
`ifdef HPDCACHE_SRAM_INIT_EN
                    init_addr_q <= init_addr_q + 1'b1;
                    if (init_addr_q == INIT_LAST) begin
                        state_q     <= StRun;
                        init_done_q <= 1'b1;
                    end
`else
                    state_q     <= StRun;
                    init_done_q <= 1'b1;
`endif
                end
                StRun: begin
                    state_q <= StRun;
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign init_done = init_done_q;

    always_comb begin
        // rst gates everything so the pins are quiet during the reset cycle itself.
        run         = (state_q == StRun) && !rst;
        // An in-flight read already owns a FIFO slot.
        credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_inflight_q};
        req_ready   = run && (credit_used < {1'b0, CNT_FULL});

        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (run) begin
            sram_cs    = req_valid && req_ready;
            sram_we    = req_we;
            sram_addr  = req_addr;
            sram_wdata = req_wdata;
        end
`ifdef HPDCACHE_SRAM_INIT_EN
        else if (!rst && (state_q == StInit)) begin
            sram_cs   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = init_addr_q;
        end
`endif
    end

    assign rsp_valid = (count_q != '0);
    assign rsp_rdata = mem_q[rd_ptr_q];
    assign push      = rd_inflight_q;
    assign pop       = rsp_valid && rsp_ready;

    // Response FIFO; sram_rdata is captured the cycle after the read was issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_inflight_q <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_q         <= '{default: '0};
        end else begin
            rd_inflight_q <= sram_cs && !sram_we && run;
            if (push) begin
                mem_q[wr_ptr_q] <= sram_rdata;
                wr_ptr_q        <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // The credit check must make an overflowing push unreachable.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == CNT_FULL)));

    a_addr_in_range: assert property (@(posedge clk) disable iff (rst)
        !(req_valid && req_ready) || ({1'b0, req_addr} < DEPTH_EXT));

endmodule

// File: tb/tb_hpdcache_sram_ctrl.sv
// Bench for hpdcache_sram_ctrl (ADDR_SIZE=4, DATA_SIZE=16, DEPTH=16, RSP_DEPTH=3) with a
// behavioural 1RW SRAM. Builds with or without HPDCACHE_SRAM_INIT_EN.
module tb_hpdcache_sram_ctrl;

`ifdef HPDCACHE_SRAM_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        init_done;
    logic        sram_cs;
    logic        sram_we;
    logic [3:0]  sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    hpdcache_sram_ctrl #(
        .ADDR_SIZE (4),
        .DATA_SIZE (16),
        .DEPTH     (16),
        .RSP_DEPTH (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .init_done  (init_done),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM, preloaded with a recognisable pattern.
    logic [15:0] sram [16];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) sram[sram_addr] = sram_wdata;
            else sram_rdata <= sram[sram_addr];
        end
    end

    function automatic logic [15:0] pat(input int a);
        return 16'hC000 | 16'(a);
    endfunction

    // Content seen by client reads of untouched words.
    function automatic logic [15:0] mem_val(input int a);
        return INIT_EN ? 16'h0000 : pat(a);
    endfunction

    typedef struct {
        logic        v;
        logic        we;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic        rr;
        logic        e_ready;
        logic        e_cs;
        logic        e_rv;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic v, input logic we, input int addr, input logic [15:0] wdata,
                       input logic rr, input logic e_ready, input logic e_cs, input logic e_rv,
                       input logic [15:0] e_rdata);
        vec_t t;
        t.v = v; t.we = we; t.addr = 4'(addr); t.wdata = wdata; t.rr = rr;
        t.e_ready = e_ready; t.e_cs = e_cs; t.e_rv = e_rv; t.e_rdata = e_rdata;
        vq.push_back(t);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic wait_init(input string name);
        for (int k = 0; k < 64 && !init_done; k++) step();
        #3;
        chk1(name, init_done, 1'b1);
        step();
    endtask

    initial begin
        logic stale;
        for (int i = 0; i < 16; i++) sram[i] = pat(i);

        // Reset with a write request pending: pins must stay quiet.
        rst = 1'b1; rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h5; req_wdata = 16'hBEEF;
        step(); step();
        #3;
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_init_done", init_done, 1'b0);
        chk1("rst_sram_cs", sram_cs, 1'b0);
        chk1("rst_sram_we", sram_we, 1'b0);
        chk16("rst_sram_addr", 16'(sram_addr), 16'h0);
        chk16("rst_sram_wdata", sram_wdata, 16'h0);
        chk16("rst_rsp_rdata", rsp_rdata, 16'h0);
        idle();
        rst = 1'b0;

`ifdef HPDCACHE_SRAM_INIT_EN
        for (int i = 0; i < 16; i++) begin
            #3;
            chk1($sformatf("init%0d_cs", i), sram_cs, 1'b1);
            chk1($sformatf("init%0d_we", i), sram_we, 1'b1);
            chk16($sformatf("init%0d_addr", i), 16'(sram_addr), 16'(i));
            chk16($sformatf("init%0d_wdata", i), sram_wdata, 16'h0);
            chk1($sformatf("init%0d_ready", i), req_ready, 1'b0);
            chk1($sformatf("init%0d_done", i), init_done, 1'b0);
            step();
        end
        #3;
        chk1("init_done_after", init_done, 1'b1);
        chk1("init_ready_after", req_ready, 1'b1);
        chk1("init_idle_cs", sram_cs, 1'b0);
        step();
`else
        #3;
        chk1("c0_init_done", init_done, 1'b0);
        chk1("c0_req_ready", req_ready, 1'b0);
        chk1("c0_sram_cs", sram_cs, 1'b0);
        step();
        #3;
        chk1("c1_init_done", init_done, 1'b1);
        chk1("c1_req_ready", req_ready, 1'b1);
        step();
`endif

        // Write then read same address back to back; response two cycles after the read.
        add(1, 1, 5, 16'hDEAD, 1, 1, 1, 0, 0);
        add(1, 0, 5, 16'h0, 1, 1, 1, 0, 0);
        add(0, 0, 0, 16'h0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0, 1, 1, 0, 1, 16'hDEAD);
        add(0, 0, 0, 16'h0, 1, 1, 0, 0, 0);
        // Eight streaming reads with rsp_ready high.
        for (int i = 0; i < 8; i++) begin
            add(1, 0, 8 + i, 16'h0, 1, 1, 1, (i >= 2), (i >= 2) ? mem_val(6 + i) : 16'h0);
        end
        add(0, 0, 0, 16'h0, 1, 1, 0, 1, mem_val(14));
        add(0, 0, 0, 16'h0, 1, 1, 0, 1, mem_val(15));
        add(0, 0, 0, 16'h0, 1, 1, 0, 0, 0);
        // Reads streaming into a stalled client: three accepted, then back-pressure.
        add(1, 0, 0, 16'h0, 0, 1, 1, 0, 0);
        add(1, 0, 1, 16'h0, 0, 1, 1, 0, 0);
        add(1, 0, 2, 16'h0, 0, 1, 1, 1, mem_val(0));
        add(1, 0, 3, 16'h0, 0, 0, 0, 1, mem_val(0));
        add(1, 0, 3, 16'h0, 0, 0, 0, 1, mem_val(0));
        add(1, 0, 3, 16'h0, 1, 0, 0, 1, mem_val(0));
        add(1, 0, 3, 16'h0, 1, 1, 1, 1, mem_val(1));
        add(0, 0, 0, 16'h0, 1, 1, 0, 1, mem_val(2));
        add(0, 0, 0, 16'h0, 1, 1, 0, 1, mem_val(3));
        add(0, 0, 0, 16'h0, 1, 1, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            req_valid = vq[i].v;
            req_we    = vq[i].we;
            req_addr  = vq[i].addr;
            req_wdata = vq[i].wdata;
            rsp_ready = vq[i].rr;
            #3;
            chk1($sformatf("v%0d_req_ready", i), req_ready, vq[i].e_ready);
            chk1($sformatf("v%0d_sram_cs", i), sram_cs, vq[i].e_cs);
            if (vq[i].e_cs) begin
                chk1($sformatf("v%0d_sram_we", i), sram_we, vq[i].we);
                chk16($sformatf("v%0d_sram_addr", i), 16'(sram_addr), 16'(vq[i].addr));
                if (vq[i].we) chk16($sformatf("v%0d_sram_wdata", i), sram_wdata, vq[i].wdata);
            end
            chk1($sformatf("v%0d_rsp_valid", i), rsp_valid, vq[i].e_rv);
            if (vq[i].e_rv) chk16($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vq[i].e_rdata);
            step();
        end
        idle();

        // Reset with two responses queued and one read in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr = 4'(i);
            #3;
            chk1($sformatf("h%0d_req_ready", i), req_ready, 1'b1);
            step();
        end
        req_valid = 1'b0;
        #3;
        chk1("h3_req_ready", req_ready, 1'b0);
        chk1("h3_rsp_valid", rsp_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        #3;
        chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
        chk16("post_rst_rsp_rdata", rsp_rdata, 16'h0);
        chk1("post_rst_init_done", init_done, 1'b0);
        stale = 1'b0;
        for (int k = 0; k < 64 && !init_done; k++) begin
            if (rsp_valid) stale = 1'b1;
            step();
        end
        for (int k = 0; k < 4; k++) begin
            #3;
            if (rsp_valid) stale = 1'b1;
            step();
        end
        chk1("post_rst_init_reached", init_done, 1'b1);
        chk1("no_stale_response", stale, 1'b0);

        // Controller still serves reads after the mid-traffic reset.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h3;
        #3;
        chk1("rd3_accept", sram_cs, 1'b1);
        step();
        idle();
        step();
        #3;
        chk1("rd3_rsp_valid", rsp_valid, 1'b1);
        chk16("rd3_rsp_rdata", rsp_rdata, mem_val(3));
        step();

`ifdef HPDCACHE_SRAM_INIT_EN
        // Reset while the init walk is at address 7 restarts it at address 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) step();
        #3;
        chk16("walk_at7_addr", 16'(sram_addr), 16'h7);
        rst = 1'b1;
        #1;
        chk1("walk_rst_cs", sram_cs, 1'b0);
        step();
        rst = 1'b0;
        #3;
        chk16("walk_restart_addr", 16'(sram_addr), 16'h0);
        chk1("walk_restart_cs", sram_cs, 1'b1);
        chk1("walk_restart_done", init_done, 1'b0);
        wait_init("walk_restart_finish");
`else
        wait_init("final_init_done");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
